// File: rtl/ufm_dump_pkg.sv
// Shared definitions for the UFM hex-dump formatter: FSM state encoding
// and the ASCII constants used to build the text lines.
package ufm_dump_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_WAIT  = 4'd0;
  localparam state_t S_A3    = 4'd1;
  localparam state_t S_A2    = 4'd2;
  localparam state_t S_A1    = 4'd3;
  localparam state_t S_A0    = 4'd4;
  localparam state_t S_COLON = 4'd5;
  localparam state_t S_SP0   = 4'd6;
  localparam state_t S_HI    = 4'd7;
  localparam state_t S_LO    = 4'd8;
  localparam state_t S_SP1   = 4'd9;
  localparam state_t S_CR    = 4'd10;
  localparam state_t S_LF    = 4'd11;

  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
//   nib_i : 4-bit value
//   asc_o : '0'..'9' or 'A'..'F'
module nibble_to_ascii
  import ufm_dump_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  always_comb begin
    if (nib_i < 4'd10) asc_o = ASC_0 + {4'h0, nib_i};
    else               asc_o = ASC_A + {4'h0, nib_i} - 8'd10;
  end

endmodule

// File: rtl/ufm_hex_dump.sv
// Formats raw UFM bytes as hex-dump text lines ("AAAA: HH HH ... \r\n")
// and writes them one character at a time into the UART.
//   clk, rst     : clock, async active-high reset
//   in_data/in_valid/in_last/in_ready : byte stream from the UFM reader
//   tx_data/tx_wr : character + single-cycle write strobe to the UART
//   tx_empty     : UART transmitter idle
//   line_active  : a text line is partially printed
module ufm_hex_dump
  import ufm_dump_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 15,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = 15'h7FA0,
  parameter int                  BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_empty,
  output logic       line_active
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            col_q;
  logic [7:0]            data_q;
  logic                  last_q;
  logic                  tx_wr_q;
  logic                  line_active_q;

  logic                  accept;
  logic                  emit;
  logic [15:0]           addr16;
  logic [3:0]            nib;
  logic [7:0]            hex_ch;
  logic [7:0]            ch;

  assign addr16 = 16'(addr_q);

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  // ---- next-state ----
  always_comb begin
    state_d = state_q;
    if (state_q == S_WAIT) begin
      if (accept) state_d = (col_q == 5'd0) ? S_A3 : S_HI;
    end else if (emit) begin
      case (state_q)
        S_A3:    state_d = S_A2;
        S_A2:    state_d = S_A1;
        S_A1:    state_d = S_A0;
        S_A0:    state_d = S_COLON;
        S_COLON: state_d = S_SP0;
        S_SP0:   state_d = S_HI;
        S_HI:    state_d = S_LO;
        S_LO:    state_d = S_SP1;
        // col_q still holds the pre-increment column here
        S_SP1:   state_d = (last_q || col_q == 5'(BYTES_PER_LINE - 1)) ? S_CR : S_WAIT;
        S_CR:    state_d = S_LF;
        default: state_d = S_WAIT;
      endcase
    end
  end

  // ---- outputs ----
  always_comb begin
    in_ready = (state_q == S_WAIT);
    accept   = in_valid && in_ready;
    // Skipping the cycle after a write gives the UART time to drop tx_empty.
    emit     = (state_q != S_WAIT) && tx_empty && !tx_wr_q;

    nib = 4'h0;
    case (state_q)
      S_A3:    nib = addr16[15:12];
      S_A2:    nib = addr16[11:8];
      S_A1:    nib = addr16[7:4];
      S_A0:    nib = addr16[3:0];
      S_HI:    nib = data_q[7:4];
      S_LO:    nib = data_q[3:0];
      default: nib = 4'h0;
    endcase

    ch = hex_ch;
    case (state_q)
      S_COLON:      ch = ASC_COLON;
      S_SP0, S_SP1: ch = ASC_SP;
      S_CR:         ch = ASC_CR;
      S_LF:         ch = ASC_LF;
      default:      ch = hex_ch;
    endcase

    tx_wr       = emit;
    tx_data     = emit ? ch : 8'h00;
    line_active = line_active_q;
  end

  nibble_to_ascii u_hex (
    .nib_i (nib),
    .asc_o (hex_ch)
  );

  // ---- datapath ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= START_ADDR;
      col_q         <= 5'd0;
      data_q        <= 8'h00;
      last_q        <= 1'b0;
      tx_wr_q       <= 1'b0;
      line_active_q <= 1'b0;
    end else begin
      tx_wr_q <= emit;
      if (accept) begin
        data_q <= in_data;
        last_q <= in_last;
        if (col_q == 5'd0) line_active_q <= 1'b1;
      end
      if (emit && state_q == S_SP1) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        col_q  <= col_q + 5'd1;
      end
      if (emit && state_q == S_LF) begin
        col_q         <= 5'd0;
        line_active_q <= 1'b0;
        if (last_q) addr_q <= START_ADDR;
      end
    end
  end

endmodule
